// File: rtl/sreg_bist_ctrl.sv
// BIST sequencer for a serial shift-register memory: fills it with a 16-bit LFSR
// pattern, then replays the same pattern while counting readback mismatches.
module sreg_bist_ctrl #(
  parameter int BITS     = 256,
  parameter int ERR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          seed,
  output logic                sreg_we,
  output logic                sreg_data_in,
  input  logic                sreg_data_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_BITS-1:0] err_count
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  state_t              state, state_nxt;
  logic [15:0]         lfsr, lfsr_nxt, lfsr_adv, lfsr_init;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [ERR_BITS-1:0] err, err_nxt;
  logic                last;

  // {seed, ~seed} always has a set bit, so the LFSR never locks up at zero
  assign lfsr_init = {seed, ~seed};
  assign lfsr_adv  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign last      = (cnt == CW'(BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= '0;
      cnt   <= '0;
      err   <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          lfsr_nxt  = lfsr_init;
          cnt_nxt   = '0;
          err_nxt   = '0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        lfsr_nxt = lfsr_adv;
        cnt_nxt  = cnt + 1'b1;
        if (last) begin
          lfsr_nxt  = lfsr_init;
          cnt_nxt   = '0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        // the pattern is rewritten as it is read, so the memory ends up unchanged
        if ((sreg_data_out != lfsr[15]) && (err != '1))
          err_nxt = err + 1'b1;
        lfsr_nxt = lfsr_adv;
        cnt_nxt  = cnt + 1'b1;
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state == FILL) || (state == CHECK);
  assign sreg_we      = busy;
  assign sreg_data_in = busy & lfsr[15];
  assign done         = (state == DONE);
  assign pass         = done && (err == '0);
  assign err_count    = err;
endmodule

// File: tb/tb_sreg_bist_ctrl.sv
// Bench for sreg_bist_ctrl: ideal/faulty shift-register memory, run-timeline model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_sreg_bist_ctrl;
  localparam int BITS = 256;
  localparam int EB   = 8;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0]    seed = 8'h00;
  logic          sreg_we, sreg_data_in, sreg_data_out, busy, done, pass;
  logic [EB-1:0] err_count;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  sreg_bist_ctrl #(.BITS(BITS), .ERR_BITS(EB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .sreg_we(sreg_we), .sreg_data_in(sreg_data_in), .sreg_data_out(sreg_data_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  // memory under test: oldest bit appears at the output, optional faults
  logic [BITS-1:0] mem = '0;
  bit inv = 1'b0, flip_next = 1'b0;
  always @(posedge clk) if (sreg_we) mem <= {mem[BITS-2:0], sreg_data_in ^ flip_next};
  assign sreg_data_out = mem[BITS-1] ^ inv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] gen_pat(input logic [7:0] s);
    logic [15:0] l;
    logic [BITS-1:0] p;
    l = {s, ~s};
    for (int i = 0; i < BITS; i++) begin
      p[i] = l[15];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return p;
  endfunction

  // model: fault mode 0 clean, 1 output inverted, 2 stored bit 17 flipped
  int mode = 0;
  int m_t = -1;
  bit m_done = 1'b0;
  int m_err = 0;
  logic [BITS-1:0] pat = '0;

  function automatic int errs(input int k);
    int e;
    case (mode)
      1:       e = k;
      2:       e = (k > 17) ? 1 : 0;
      default: e = 0;
    endcase
    return (e > 255) ? 255 : e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1; m_done = 1'b0; m_err = 0;
    end else if (m_t >= 0) begin
      if (m_t >= BITS) m_err = errs(m_t - BITS + 1);
      m_t++;
      if (m_t == 2 * BITS) begin m_t = -1; m_done = 1'b1; end
    end else if (start) begin
      m_t = 0; m_done = 1'b0; m_err = 0; pat = gen_pat(seed);
    end
  end

  always @(negedge clk) begin
    bit eb;
    eb = (m_t >= 0);
    chk("busy", busy, eb);
    chk("we", sreg_we, eb);
    chk("data_in", sreg_data_in, eb ? pat[m_t % BITS] : 1'b0);
    chk("done", done, m_done);
    chk("pass", pass, m_done && (m_err == 0));
    chk("err_count", err_count, m_err);
  end

  task automatic zeros_lit(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_we"}, sreg_we, 0);
    chk({nm, "_din"}, sreg_data_in, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_err"}, err_count, 0);
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    while (!done && c < 3 * BITS) begin @(negedge clk); c++; end
    chk({nm, "_done_seen"}, done, 1);
  endtask

  // one run from a negedge in IDLE/DONE; pulses = extra start pulses mid-run
  task automatic run(input string nm, input logic [7:0] s, input int md, input bit pulses,
                     input logic [7:0] exp_err, input bit exp_pass, input logic [15:0] exp_head);
    int nb = 0;
    logic [15:0] head = '0;
    mode = md; inv = (md == 1); seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3 * BITS && !done; c++) begin
      if (busy) nb++;
      if (c < 16) head = {head[14:0], sreg_data_in};
      flip_next = (md == 2) && (c == 17);
      start = pulses && (c == 10 || c == BITS + 50);
      @(negedge clk);
    end
    flip_next = 1'b0; start = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_cycles"}, nb, 2 * BITS);
    chk({nm, "_head"}, head, exp_head);
    chk({nm, "_err"}, err_count, exp_err);
    chk({nm, "_pass"}, pass, exp_pass);
  endtask

  initial begin
    logic [BITS-1:0] p;
    logic [15:0] f;
    repeat (3) @(negedge clk);
    zeros_lit("reset");
    rst_n = 1'b1;

    // pin the pattern generator against hand-derived heads
    p = gen_pat(8'h00); f = '0;
    for (int i = 0; i < 16; i++) f = {f[14:0], p[i]};
    chk("pat_head_00", f, 16'h00FF);
    p = gen_pat(8'h5A); f = '0;
    for (int i = 0; i < 16; i++) f = {f[14:0], p[i]};
    chk("pat_head_5a", f, 16'h5AA5);

    @(negedge clk);
    run("clean", 8'h00, 0, 1'b0, 8'd0, 1'b1, 16'h00FF);
    run("inverted", 8'h00, 1, 1'b0, 8'd255, 1'b0, 16'h00FF);
    run("flip17", 8'h3C, 2, 1'b0, 8'd1, 1'b0, 16'h3CC3);
    run("pulses", 8'h00, 0, 1'b1, 8'd0, 1'b1, 16'h00FF);

    // held start in DONE restarts and clears the saturated count
    run("inv2", 8'hC3, 1, 1'b0, 8'd255, 1'b0, 16'hC33C);
    mode = 0; inv = 1'b0; seed = 8'h00; start = 1'b1;
    @(negedge clk);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_err", err_count, 0);
    wait_done("held1");
    chk("held1_pass", pass, 1);
    @(negedge clk);
    chk("backtoback_busy", busy, 1);
    start = 1'b0;
    wait_done("held2");

    // async reset mid-CHECK at cnt=100
    seed = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3 * BITS && m_t != BITS + 100; c++) @(negedge clk);
    chk("midcheck_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 zeros_lit("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_we", sreg_we, 0);
    chk("post_rst_busy", busy, 0);
    run("rerun5a", 8'h5A, 0, 1'b0, 8'd0, 1'b1, 16'h5AA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
